// File: rtl/dram_arb_pkg.sv
// Shared types and sizing helpers for the data-RAM arbiter.
// Used by dram_arbiter and its optional starvation counter.
package dram_arb_pkg;

   localparam int DRAM_ADDR_W = 6;
   localparam int DRAM_DATA_W = 32;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_ACK  = 1'b1
   } arb_state_e;

   // Counter wide enough to hold 0..lim inclusive.
   function automatic int cnt_w(input int lim);
      return (lim < 1) ? 1 : $clog2(lim + 1);
   endfunction

endpackage

// File: rtl/dram_arb_starve_cnt.sv
// Saturating denied-request counter; sat_o flags that the limit was reached.
// Clear has priority over increment; state is cleared by reset.
module dram_arb_starve_cnt
   import dram_arb_pkg::*;
#(
   parameter int LIM = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic inc_i,
   input  logic clr_i,
   output logic sat_o
);

   localparam int W = cnt_w(LIM);
   localparam logic [W-1:0] LIM_W = W'(LIM);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != LIM_W)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sat_o = (cnt_q == LIM_W);

endmodule

// File: rtl/dram_arbiter.sv
// Data-RAM arbiter: MEM stage has priority, external port uses req/ack.
// Optional starvation guard (DRAM_ARB_STARVE_EN) forces a one-cycle external grant.
module dram_arbiter
   import dram_arb_pkg::*;
#(
   parameter int ADDR_W     = DRAM_ADDR_W,
   parameter int DATA_W     = DRAM_DATA_W,
   parameter int STARVE_LIM = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_we,
   input  logic              cpu_re,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_ack,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   arb_state_e        state_q, state_d;
   logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
   logic              cpu_busy;
   logic              force_grant;
   logic              grant_ext;

   assign cpu_busy = cpu_we | cpu_re;

   // Reset gates the grant so the RAM stays with the CPU while reset is held.
   assign grant_ext = !reset && (state_q == ARB_IDLE) && ext_req
                      && (!cpu_busy || force_grant);

`ifdef DRAM_ARB_STARVE_EN
   dram_arb_starve_cnt #(
      .LIM (STARVE_LIM)
   ) u_starve_cnt (
      .clk   (clk),
      .reset (reset),
      .inc_i ((state_q == ARB_IDLE) && ext_req && !grant_ext),
      .clr_i (grant_ext),
      .sat_o (force_grant)
   );
   assign cpu_stall = grant_ext & cpu_busy;
`else
   logic unused_cfg;
   assign unused_cfg  = (STARVE_LIM < 1);
   assign force_grant = 1'b0;
   assign cpu_stall   = 1'b0;
`endif

   always_comb begin
      if (grant_ext) begin
         ram_addr = ext_addr;
         ram_we   = ext_we;
         ram_din  = ext_wdata;
      end else begin
         ram_addr = cpu_addr;
         ram_we   = cpu_we & !cpu_stall;
         ram_din  = cpu_wdata;
      end
   end

   always_comb begin
      state_d     = ARB_IDLE;
      ext_rdata_d = ext_rdata_q;
      if (grant_ext) begin
         state_d     = ARB_ACK;
         ext_rdata_d = ram_dout;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ARB_IDLE;
         ext_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         ext_rdata_q <= ext_rdata_d;
      end
   end

   assign ext_ack   = (state_q == ARB_ACK);
   assign ext_rdata = ext_rdata_q;
   assign cpu_rdata = ram_dout;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed scenarios plus random traffic
// against a transaction-level model of the shared RAM and the external port.
module tb_dram_arbiter;

   localparam int ADDR_W     = 6;
   localparam int DATA_W     = 32;
   localparam int STARVE_LIM = 8;
   localparam int DEPTH      = 64;

   logic              clk = 1'b0;
   logic              reset;
   logic              cpu_we, cpu_re;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;
   logic              ext_req, ext_we;
   logic [ADDR_W-1:0] ext_addr;
   logic [DATA_W-1:0] ext_wdata;
   logic              ext_ack;
   logic [DATA_W-1:0] ext_rdata;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;

   logic [DATA_W-1:0] ram [DEPTH];
   logic              mem_init;

   logic [DATA_W-1:0] m_mem [DEPTH];
   bit                m_ack;
   logic [DATA_W-1:0] m_rdata;
   int                m_starve;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dram_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .STARVE_LIM (STARVE_LIM)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_we    (cpu_we),
      .cpu_re    (cpu_re),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .ext_req   (ext_req),
      .ext_we    (ext_we),
      .ext_addr  (ext_addr),
      .ext_wdata (ext_wdata),
      .ext_ack   (ext_ack),
      .ext_rdata (ext_rdata),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout)
   );

   // Environment RAM: asynchronous read, synchronous write.
   assign ram_dout = ram[ram_addr];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= 32'hA000_0000 | i;
      end else if (ram_we) begin
         ram[ram_addr] <= ram_din;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One arbitration cycle: entered just after a falling edge with inputs
   // already driven; returns at the next falling edge.
   task automatic cycle();
      bit busy, frc, grant;
      #1;
      busy = cpu_we | cpu_re;
      frc  = 1'b0;
`ifdef DRAM_ARB_STARVE_EN
      frc = (m_starve >= STARVE_LIM);
`endif
      grant = !m_ack && ext_req && (!busy || frc);
      check("ext_ack",   ext_ack,   m_ack);
      check("ext_rdata", ext_rdata, m_rdata);
      check("cpu_stall", cpu_stall, grant && busy);
      check("ram_we",    ram_we,    grant ? ext_we : (cpu_we && !(grant && busy)));
      check("ram_addr",  ram_addr,  grant ? ext_addr : cpu_addr);
      if (!grant) check("cpu_rdata", cpu_rdata, m_mem[cpu_addr]);
      @(posedge clk);
      if (grant) begin
         m_rdata = m_mem[ext_addr];
         if (ext_we) m_mem[ext_addr] = ext_wdata;
         m_starve = 0;
      end else begin
         if (cpu_we) m_mem[cpu_addr] = cpu_wdata;
         if (!m_ack && ext_req && m_starve < STARVE_LIM) m_starve++;
      end
      m_ack = grant;
      @(negedge clk);
   endtask

   task automatic cpu_idle();
      cpu_we    = 1'b0;
      cpu_re    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
   endtask

   initial begin
      int first_stall;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'hA000_0000 | i;
      m_ack = 1'b0; m_rdata = '0; m_starve = 0;

      // Reset: grant suppressed even with a pending external write.
      reset = 1'b1; mem_init = 1'b1;
      cpu_idle();
      ext_req = 1'b1; ext_we = 1'b1; ext_addr = 6'd5; ext_wdata = 32'h1111_1111;
      @(negedge clk); #1;
      check("rst_ack",   ext_ack,   1'b0);
      check("rst_rdata", ext_rdata, 32'h0);
      check("rst_stall", cpu_stall, 1'b0);
      check("rst_ramwe", ram_we,    1'b0);
      @(negedge clk);
      mem_init = 1'b0; reset = 1'b0;

      // External write of addr 5, CPU idle; ack returns the old word.
      ext_req = 1'b1; ext_we = 1'b1; ext_addr = 6'd5; ext_wdata = 32'hDEAD_BEEF;
      cycle();
      ext_req = 1'b0;
      #1;
      check("wr5_ack", ext_ack,   1'b1);
      check("wr5_old", ext_rdata, 32'hA000_0005);
      cycle();
      cpu_re = 1'b1; cpu_addr = 6'd5;
      #1;
      check("rd5_data",  cpu_rdata, 32'hDEAD_BEEF);
      check("rd5_stall", cpu_stall, 1'b0);
      cycle();

      // CPU reads addr 3 every cycle while an external read of addr 4 waits.
      cpu_re = 1'b1; cpu_addr = 6'd3;
      ext_req = 1'b1; ext_we = 1'b0; ext_addr = 6'd4;
      first_stall = -1;
      for (int k = 0; k < 12; k++) begin
         #1;
         if (cpu_stall && first_stall < 0) first_stall = k;
         cycle();
      end
`ifdef DRAM_ARB_STARVE_EN
      check("starve_first", first_stall, STARVE_LIM);
`else
      check("no_starve_stall", first_stall, -1);
`endif
      cpu_re = 1'b0;
      #1;
      check("drop_re_grant", ram_addr, 6'd4);
      cycle();
      ext_req = 1'b0;
      #1;
      check("drop_re_ack",   ext_ack,   1'b1);
      check("drop_re_rdata", ext_rdata, 32'hA000_0004);
      cycle();

      // we & re together at addr 7: a write, and the external port loses.
      cpu_we = 1'b1; cpu_re = 1'b1; cpu_addr = 6'd7; cpu_wdata = 32'h12;
      ext_req = 1'b1; ext_we = 1'b0; ext_addr = 6'd8;
      #1;
      check("wr7_ramwe", ram_we,   1'b1);
      check("wr7_addr",  ram_addr, 6'd7);
      cycle();
      cpu_we = 1'b0;
      #1;
      check("rd7_data", cpu_rdata, 32'h12);
      cycle();
      cpu_idle();
      cycle();
      ext_req = 1'b0;
      #1;
      check("rd8_rdata", ext_rdata, 32'hA000_0008);
      cycle();

      // Back-to-back external reads with ext_req held high.
      ext_req = 1'b1; ext_we = 1'b0; ext_addr = 6'd1;
      cycle();
      ext_addr = 6'd2;
      #1;
      check("b2b_ack1",   ext_ack,   1'b1);
      check("b2b_rdata1", ext_rdata, 32'hA000_0001);
      cycle();
      #1;
      check("b2b_gap", ext_ack, 1'b0);
      cycle();
      ext_req = 1'b0;
      #1;
      check("b2b_ack2",   ext_ack,   1'b1);
      check("b2b_rdata2", ext_rdata, 32'hA000_0002);
      cycle();

      // Reset asserted in the middle of the ack cycle.
      ext_req = 1'b1; ext_we = 1'b0; ext_addr = 6'd9;
      cycle();
      ext_req = 1'b0;
      #1;
      check("mid_ack_pre", ext_ack, 1'b1);
      reset = 1'b1;
      #1;
      check("mid_ack_drop",  ext_ack,   1'b0);
      check("mid_ack_rdata", ext_rdata, 32'h0);
      @(posedge clk); #1;
      check("mid_ack_hold", ext_ack, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      m_ack = 1'b0; m_rdata = '0; m_starve = 0;
      cycle();

      // Random traffic; the requester holds its request until acknowledged.
      for (int n = 0; n < 1500; n++) begin
         cpu_we    = ($urandom_range(0, 3) == 0);
         cpu_re    = ($urandom_range(0, 2) == 0);
         cpu_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
         cpu_wdata = $urandom;
         if (!ext_req || m_ack) begin
            ext_req   = ($urandom_range(0, 1) == 1);
            ext_we    = ($urandom_range(0, 1) == 1);
            ext_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
            ext_wdata = $urandom;
         end
         cycle();
      end
      cpu_idle();
      for (int k = 0; k < 3 && ext_req && !m_ack; k++) cycle();
      ext_req = 1'b0;
      cycle();

      for (int i = 0; i < DEPTH; i++) check("mem_final", ram[i], m_mem[i]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
